reg_file_32: RTL and testbench

Architectural register file of the single-cycle MIPS datapath, sitting directly downstream of the ALU (add/sub/slt/logic units). Provides two combinational read ports (rs, rt) feeding the ALU operands and one clocked write port accepting the ALU result as rd. Suppresses the write and raises a sticky overflow exception flag when a trapping arithmetic result overflowed. Register $0 is hardwired to zero.

---
 rtl/mips_pkg.sv | 11 +
 rtl/reg_en_32.sv | 24 ++
 rtl/reg_file_32.sv | 74 +++++++
 tb/tb_reg_file_32.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath.
//   WIDTH    : default register data width
//   ADDR_W   : default register index width
//   REG_ZERO : index of the hardwired-zero register
//   REG_RA   : index of the return-address register (highest index)
package mips_pkg;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/reg_en_32.sv
// Single architectural register with enable and asynchronous clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   en    : load d on the next rising edge
//   d     : load data
//   q     : stored value
module reg_en_32
   import mips_pkg::*;
#(
   parameter int DW = WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/reg_file_32.sv
// Architectural register file: two combinational read ports, one clocked
// write port, $0 hardwired to zero, sticky overflow-trap exception flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rs_addr / rs_data   : read port A (no write-to-read bypass)
//   rt_addr / rt_data   : read port B
//   rd_addr, rd_data    : write index and data (ALU result)
//   reg_write           : write request this cycle
//   trap_ovf, overflow  : trapping op / ALU overflow; both set -> write suppressed
//   ovf_exc, ovf_reg    : sticky exception flag and rd_addr of the first trapped write
//   ovf_ack             : clears ovf_exc
module reg_file_32
   import mips_pkg::*;
#(
   parameter int DW = WIDTH,
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   input  logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   input  logic          reg_write,
   input  logic          trap_ovf,
   input  logic          overflow,
   output logic          ovf_exc,
   input  logic          ovf_ack,
   output logic [AW-1:0] ovf_reg
);

   localparam int NREG = 2 ** AW;

   logic          trap_evt;
   logic          wr_ok;
   logic [DW-1:0] regs [NREG];

   assign trap_evt = reg_write & trap_ovf & overflow;
   assign wr_ok    = reg_write & (rd_addr != AW'(REG_ZERO)) & ~(trap_ovf & overflow);

   // Slot 0 is a constant so the read muxes need no separate zero forcing.
   assign regs[0] = '0;

   for (genvar i = 1; i < NREG; i++) begin : g_reg
      logic en;
      assign en = wr_ok & (rd_addr == AW'(i));
      reg_en_32 #(.DW(DW)) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .d     (rd_data),
         .q     (regs[i])
      );
   end

   assign rs_data = regs[rs_addr];
   assign rt_data = regs[rt_addr];

   // A new trap captures when the flag is clear or being acked in the same
   // cycle (new event wins over ack); otherwise the first event is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_exc <= 1'b0;
         ovf_reg <= '0;
      end else if (trap_evt && (!ovf_exc || ovf_ack)) begin
         ovf_exc <= 1'b1;
         ovf_reg <= rd_addr;
      end else if (ovf_ack) begin
         ovf_exc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file_32.sv
module tb_reg_file_32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr, rd_addr;
   logic [31:0] rd_data;
   logic        reg_write, trap_ovf, overflow, ovf_ack;
   logic [31:0] rs_data, rt_data;
   logic        ovf_exc;
   logic [4:0]  ovf_reg;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [31:0] mem [32];
   logic        m_exc;
   logic [4:0]  m_oreg;

   always #5 clk = ~clk;

   reg_file_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .reg_write (reg_write),
      .trap_ovf  (trap_ovf),
      .overflow  (overflow),
      .ovf_exc   (ovf_exc),
      .ovf_ack   (ovf_ack),
      .ovf_reg   (ovf_reg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : mem[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      m_exc  = 1'b0;
      m_oreg = 5'd0;
   endtask

   // Architectural effect of one clock edge, stated directly from the ISA rules.
   task automatic model_edge(input logic rw, input logic [4:0] rd, input logic [31:0] d,
                             input logic trap, input logic ov, input logic ack);
      if (rw && trap && ov) begin
         if (!m_exc || ack) begin
            m_exc  = 1'b1;
            m_oreg = rd;
         end
      end else begin
         if (ack) m_exc = 1'b0;
         if (rw && rd != 5'd0) mem[rd] = d;
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic do_cycle(input logic rw, input logic [4:0] rd, input logic [31:0] d,
                           input logic trap, input logic ov, input logic ack,
                           input logic [4:0] ra, input logic [4:0] rb);
      reg_write = rw; rd_addr = rd; rd_data = d;
      trap_ovf = trap; overflow = ov; ovf_ack = ack;
      rs_addr = ra; rt_addr = rb;
      #1;
      chk("rs_pre", rs_data, model_rd(ra));
      chk("rt_pre", rt_data, model_rd(rb));
      @(posedge clk);
      model_edge(rw, rd, d, trap, ov, ack);
      #1;
      chk("rs_post", rs_data, model_rd(ra));
      chk("rt_post", rt_data, model_rd(rb));
      chk("ovf_exc", 32'(ovf_exc), 32'(m_exc));
      chk("ovf_reg", 32'(ovf_reg), 32'(m_oreg));
      @(negedge clk);
   endtask

   task automatic idle();
      do_cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
   endtask

   task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
      rs_addr = a; rt_addr = a;
      #1;
      chk({tag, "_rs"}, rs_data, exp);
      chk({tag, "_rt"}, rt_data, exp);
   endtask

   initial begin
      rst_n = 1'b1;
      reg_write = 1'b0; rd_addr = 5'd0; rd_data = 32'h0;
      trap_ovf = 1'b0; overflow = 1'b0; ovf_ack = 1'b0;
      rs_addr = 5'd0; rt_addr = 5'd0;
      model_reset();

      // asynchronous reset asserted mid-cycle
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i); rt_addr = 5'(31 - i);
         #1;
         chk("rst_rs", rs_data, 32'h0);
         chk("rst_rt", rt_data, 32'h0);
      end
      chk("rst_exc", 32'(ovf_exc), 32'h0);
      chk("rst_oreg", 32'(ovf_reg), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic write/read, no bypass (first write right after reset release)
      do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      peek("r5_a", 5'd5, 32'hDEADBEEF);
      do_cycle(1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5);
      peek("r5_b", 5'd5, 32'h12345678);

      // $0 protection
      do_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      peek("r0", 5'd0, 32'h0);
      chk("r0_exc", 32'(ovf_exc), 32'h0);

      // trapping overflow, then a second one that must not overwrite ovf_reg
      do_cycle(1'b1, 5'd8, 32'h11111111, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0);
      do_cycle(1'b1, 5'd8, 32'h80000000, 1'b1, 1'b1, 1'b0, 5'd8, 5'd0);
      peek("r8_keep", 5'd8, 32'h11111111);
      chk("trap_exc", 32'(ovf_exc), 32'h1);
      chk("trap_reg", 32'(ovf_reg), 32'd8);
      do_cycle(1'b1, 5'd9, 32'h80000000, 1'b1, 1'b1, 1'b0, 5'd9, 5'd0);
      peek("r9_keep", 5'd9, 32'h0);
      chk("trap2_reg", 32'(ovf_reg), 32'd8);

      // non-trapping overflow commits normally
      do_cycle(1'b1, 5'd3, 32'h00000001, 1'b0, 1'b1, 1'b0, 5'd3, 5'd3);
      peek("r3_slt", 5'd3, 32'h1);
      chk("slt_exc", 32'(ovf_exc), 32'h1);

      // ack collides with a new trap: new event wins, then plain ack clears
      do_cycle(1'b1, 5'd12, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 5'd12, 5'd0);
      chk("coll_exc", 32'(ovf_exc), 32'h1);
      chk("coll_reg", 32'(ovf_reg), 32'd12);
      do_cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
      chk("ack_exc", 32'(ovf_exc), 32'h0);

      // trap on $0 still raises the flag
      do_cycle(1'b1, 5'd0, 32'h1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
      chk("trap0_exc", 32'(ovf_exc), 32'h1);
      chk("trap0_reg", 32'(ovf_reg), 32'd0);
      do_cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);

      // randomized traffic against the reference model
      for (int n = 0; n < 500; n++) begin
         do_cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      // reset mid-operation: pending write lost, flag cleared asynchronously
      do_cycle(1'b1, 5'd20, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 5'd20, 5'd0);
      reg_write = 1'b1; rd_addr = 5'd21; rd_data = 32'hCAFEF00D;
      trap_ovf = 1'b0; overflow = 1'b0; ovf_ack = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("mrst_exc", 32'(ovf_exc), 32'h0);
      peek("mrst_r5", 5'd5, 32'h0);
      @(posedge clk);
      #1;
      peek("mrst_r21", 5'd21, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle(1'b1, 5'd21, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 5'd21, 5'd0);
      peek("post_r21", 5'd21, 32'h0BADF00D);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
